ex_div: RTL and testbench

EX_DIV -- requirements
Module: ex_div

---
 rtl/ex_div_pkg.sv | 21 ++
 rtl/ex_div.sv | 178 +++++++++++++++++
 tb/tb_ex_div.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_div_pkg.sv
// Shared constants for the EX-stage divider: data width, operation codes and FSM states.
package ex_div_pkg;

  localparam int DATA_WIDTH = 64;
  localparam logic [4:0] REG_ADDR_ZERO = 5'd0;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider: N+2 cycles to done (N = 32 for W ops, DW otherwise), 1 cycle for /0 and overflow.
// Stalls the pipeline through div_busy_o while computing; starts during CALC/FIX are ignored, flush kills the op.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          div_start_i,
  input  logic [1:0]    div_op_i,
  input  logic          word_intercept_i,
  input  logic [DW-1:0] div_num1_i,
  input  logic [DW-1:0] div_num2_i,
  input  logic [4:0]    addr_rd_i,
  input  logic          flush_i,
  output logic          div_busy_o,
  output logic          div_done_o,
  output logic [DW-1:0] div_result_o,
  output logic [4:0]    addr_rd_o,
  output logic          reg_wr_en_o
);

  localparam int CW = $clog2(DW + 1);
  localparam int WSH = DW - 32;
  localparam logic [CW-1:0] N_FULL = CW'(DW);
  localparam logic [CW-1:0] N_WORD = CW'(32);

  div_state_e state_q, state_d;

  logic          rem_op_q, rem_op_d;
  logic          w_q, w_d;
  logic          neg_quot_q, neg_quot_d;
  logic          neg_rem_q, neg_rem_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] dvsr_q, dvsr_d;
  logic [DW-1:0] result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    rd_q, rd_d;
  logic [4:0]    rd_out_q, rd_out_d;

  logic          signed_op, rem_op, a_neg, b_neg;
  logic          div_zero, ovf, special, accept_state;
  logic [DW-1:0] a_ext, b_ext, abs_a, abs_b, special_res, fix_res;
  logic [DW:0]   rem_shift, rem_sub;

  function automatic logic [DW-1:0] w_fix(input logic w, input logic [DW-1:0] v);
    return w ? {{WSH{v[31]}}, v[31:0]} : v;
  endfunction

  // Operand conditioning and the cycle-0 special-case detection.
  always_comb begin
    signed_op = (div_op_i == OP_DIV) || (div_op_i == OP_REM);
    rem_op    = (div_op_i == OP_REM) || (div_op_i == OP_REMU);
    if (word_intercept_i) begin
      a_ext = signed_op ? {{WSH{div_num1_i[31]}}, div_num1_i[31:0]} : {{WSH{1'b0}}, div_num1_i[31:0]};
      b_ext = signed_op ? {{WSH{div_num2_i[31]}}, div_num2_i[31:0]} : {{WSH{1'b0}}, div_num2_i[31:0]};
    end else begin
      a_ext = div_num1_i;
      b_ext = div_num2_i;
    end
    a_neg    = signed_op & a_ext[DW-1];
    b_neg    = signed_op & b_ext[DW-1];
    abs_a    = a_neg ? -a_ext : a_ext;
    abs_b    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    ovf      = signed_op && (b_ext == {DW{1'b1}}) &&
               (word_intercept_i ? (a_ext[31:0] == 32'h8000_0000)
                                 : (a_ext == {1'b1, {(DW-1){1'b0}}}));
    special  = div_zero | ovf;
    if (div_zero) special_res = rem_op ? a_ext : {DW{1'b1}};
    else          special_res = rem_op ? '0 : a_ext;
    special_res  = w_fix(word_intercept_i, special_res);
    accept_state = (state_q == ST_IDLE) || (state_q == ST_DONE);
  end

  always_comb begin
    rem_shift = {rem_q, quot_q[DW-1]};
    rem_sub   = rem_shift - {1'b0, dvsr_q};
    fix_res   = w_fix(w_q, rem_op_q ? (neg_rem_q ? -rem_q : rem_q)
                                    : (neg_quot_q ? -quot_q : quot_q));
  end

  always_comb begin
    state_d    = state_q;
    rem_op_d   = rem_op_q;
    w_d        = w_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    rd_out_d   = rd_out_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (div_start_i) begin
          rem_op_d   = rem_op;
          w_d        = word_intercept_i;
          neg_quot_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          quot_d     = word_intercept_i ? (abs_a << WSH) : abs_a;
          rem_d      = '0;
          dvsr_d     = abs_b;
          cnt_d      = word_intercept_i ? N_WORD : N_FULL;
          rd_d       = addr_rd_i;
          if (special) begin
            state_d  = ST_DONE;
            result_d = special_res;
            rd_out_d = addr_rd_i;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        // No borrow means the shifted remainder covers the divisor: quotient bit 1.
        quot_d = {quot_q[DW-2:0], ~rem_sub[DW]};
        rem_d  = rem_sub[DW] ? rem_shift[DW-1:0] : rem_sub[DW-1:0];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d = fix_res;
        rd_out_d = rd_q;
        state_d  = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_i) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rem_op_q   <= 1'b0;
      w_q        <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      rd_q       <= REG_ADDR_ZERO;
      rd_out_q   <= REG_ADDR_ZERO;
    end else begin
      state_q    <= state_d;
      rem_op_q   <= rem_op_d;
      w_q        <= w_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      rd_out_q   <= rd_out_d;
    end
  end

  assign div_busy_o   = ((state_q == ST_CALC) || (state_q == ST_FIX) ||
                         (div_start_i && accept_state && !special)) && !flush_i && rst_n;
  assign div_done_o   = (state_q == ST_DONE);
  assign reg_wr_en_o  = (state_q == ST_DONE);
  assign div_result_o = result_q;
  assign addr_rd_o    = rd_out_q;

endmodule

// File: tb/tb_ex_div.sv
// Directed bench for ex_div: vector table for results/latency plus hand sequences for ignore, flush and reset.
module tb_ex_div;

  localparam logic [1:0] D_DIV  = 2'b00;
  localparam logic [1:0] D_DIVU = 2'b01;
  localparam logic [1:0] D_REM  = 2'b10;
  localparam logic [1:0] D_REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div_start_i;
  logic [1:0]  div_op_i;
  logic        word_intercept_i;
  logic [63:0] div_num1_i;
  logic [63:0] div_num2_i;
  logic [4:0]  addr_rd_i;
  logic        flush_i;
  logic        div_busy_o;
  logic        div_done_o;
  logic [63:0] div_result_o;
  logic [4:0]  addr_rd_o;
  logic        reg_wr_en_o;

  ex_div #(.DW(64)) dut (
    .clk(clk), .rst_n(rst_n), .div_start_i(div_start_i), .div_op_i(div_op_i),
    .word_intercept_i(word_intercept_i), .div_num1_i(div_num1_i), .div_num2_i(div_num2_i),
    .addr_rd_i(addr_rd_i), .flush_i(flush_i), .div_busy_o(div_busy_o), .div_done_o(div_done_o),
    .div_result_o(div_result_o), .addr_rd_o(addr_rd_o), .reg_wr_en_o(reg_wr_en_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp_res;
    int          exp_done;
    int          exp_busy;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [1:0] op, input logic w, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp_res, input int exp_done);
    vec_t v;
    v.name = name; v.op = op; v.w = w; v.a = a; v.b = b;
    v.rd = 5'(vq.size() + 1);
    v.exp_res = exp_res; v.exp_done = exp_done;
    v.exp_busy = (exp_done == 1) ? 0 : exp_done;
    vq.push_back(v);
  endtask

  task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd);
    div_start_i = 1'b1; div_op_i = op; word_intercept_i = w;
    div_num1_i = a; div_num2_i = b; addr_rd_i = rd;
  endtask

  // Starts v in cycle 0; optionally pulses an extra start at ign_cyc which must be ignored.
  task automatic run_vec(input vec_t v, input int ign_cyc);
    int          done_cyc;
    int          busy_cnt;
    logic [63:0] res;
    logic [4:0]  rd_got;
    logic        wr;
    done_cyc = -1; busy_cnt = 0; res = '0; rd_got = '0; wr = 1'b0;
    @(posedge clk); #1;
    issue(v.op, v.w, v.a, v.b, v.rd);
    for (int cyc = 0; cyc < 120 && done_cyc < 0; cyc++) begin
      if (cyc == ign_cyc) issue(D_REMU, 1'b0, 64'h55, 64'h0, 5'd31);
      @(negedge clk);
      if (div_busy_o) busy_cnt++;
      if (div_done_o) begin
        done_cyc = cyc; res = div_result_o; rd_got = addr_rd_o; wr = reg_wr_en_o;
      end
      @(posedge clk); #1;
      div_start_i = 1'b0;
    end
    check({v.name, "_done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
    check({v.name, "_busy_cycles"}, 64'(busy_cnt), 64'(v.exp_busy));
    check({v.name, "_result"}, res, v.exp_res);
    check({v.name, "_addr_rd"}, 64'(rd_got), 64'(v.rd));
    check({v.name, "_wr_en"}, 64'(wr), 64'd1);
    @(negedge clk);
    check({v.name, "_done_pulse_end"}, 64'(div_done_o), 64'd0);
    check({v.name, "_result_hold"}, div_result_o, v.exp_res);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          bad;
    int          dones;
    logic [63:0] prev_res;

    add("div_20_m3",     D_DIV,  1'b0, 64'd20,                   64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 66);
    add("rem_m20_3",     D_REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFEC,  64'd3,                   64'hFFFF_FFFF_FFFF_FFFE, 66);
    add("remu_7_7",      D_REMU, 1'b0, 64'd7,                    64'd7,                   64'd0,                   66);
    add("divu_by0",      D_DIVU, 1'b0, 64'h1234,                 64'd0,                   64'hFFFF_FFFF_FFFF_FFFF, 1);
    add("remu_by0",      D_REMU, 1'b0, 64'h1234,                 64'd0,                   64'h1234,                1);
    add("div_ovf",       D_DIV,  1'b0, 64'h8000_0000_0000_0000,  64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    add("rem_ovf",       D_REM,  1'b0, 64'h8000_0000_0000_0000,  64'hFFFF_FFFF_FFFF_FFFF, 64'd0,                   1);
    add("divw_m8_2",     D_DIV,  1'b1, 64'h0000_0001_FFFF_FFF8,  64'd2,                   64'hFFFF_FFFF_FFFF_FFFC, 34);
    add("divu_100_7",    D_DIVU, 1'b0, 64'd100,                  64'd7,                   64'd14,                  66);
    add("div_m100_m7",   D_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C,  64'hFFFF_FFFF_FFFF_FFF9, 64'd14,                  66);
    add("divuw_sext",    D_DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE,  64'd1,                   64'hFFFF_FFFF_FFFF_FFFE, 34);
    add("remw_m7_2",     D_REM,  1'b1, 64'hFFFF_FFFF_FFFF_FFF9,  64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 34);
    add("remuw_by0",     D_REMU, 1'b1, 64'h0000_0005_8000_0001,  64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 1);
    add("divw_ovf",      D_DIV,  1'b1, 64'h0000_0000_8000_0000,  64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);

    rst_n = 1'b0; flush_i = 1'b0;
    issue(D_DIV, 1'b0, 64'd20, 64'd3, 5'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(div_busy_o), 64'd0);
    check("reset_done", 64'(div_done_o), 64'd0);
    check("reset_wr_en", 64'(reg_wr_en_o), 64'd0);
    check("reset_result", div_result_o, 64'd0);
    check("reset_addr_rd", 64'(addr_rd_o), 64'd0);
    div_start_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vq[i]) run_vec(vq[i], -1);

    // A start arriving mid-calculation must not disturb the op in flight.
    run_vec(vq[8], 5);

    // Flush at cycle 10: busy drops immediately, no done, result untouched.
    prev_res = div_result_o;
    bad = 0; dones = 0;
    @(posedge clk); #1;
    issue(D_DIV, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 5'd9);
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc == 10) flush_i = 1'b1;
      @(negedge clk);
      if ((cyc < 10) != div_busy_o) bad++;
      if (div_done_o) dones++;
      @(posedge clk); #1;
      div_start_i = 1'b0; flush_i = 1'b0;
    end
    check("flush_busy_profile", 64'(bad), 64'd0);
    check("flush_no_done", 64'(dones), 64'd0);
    check("flush_result_hold", div_result_o, prev_res);
    run_vec(vq[0], -1);

    // Flush wins over a simultaneous start.
    bad = 0; dones = 0;
    @(posedge clk); #1;
    issue(D_DIVU, 1'b0, 64'd100, 64'd7, 5'd4);
    flush_i = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (div_busy_o) bad++;
      if (div_done_o) dones++;
      @(posedge clk); #1;
      div_start_i = 1'b0; flush_i = 1'b0;
    end
    check("flush_start_busy", 64'(bad), 64'd0);
    check("flush_start_no_done", 64'(dones), 64'd0);

    // Reset at cycle 20 abandons the op and clears the result registers.
    bad = 0; dones = 0;
    @(posedge clk); #1;
    issue(D_DIV, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 5'd12);
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc == 20) rst_n = 1'b0;
      @(negedge clk);
      if ((cyc < 20) != div_busy_o) bad++;
      if (div_done_o) dones++;
      @(posedge clk); #1;
      div_start_i = 1'b0; rst_n = 1'b1;
    end
    check("rst_busy_profile", 64'(bad), 64'd0);
    check("rst_no_done", 64'(dones), 64'd0);
    check("rst_result_cleared", div_result_o, 64'd0);
    check("rst_addr_cleared", 64'(addr_rd_o), 64'd0);
    run_vec(vq[1], -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
